mod_n_updown_counter: RTL and testbench
=======================================

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits (legal range 1..32).
REQ-002 Parameter MODULUS, default 16, SHALL set the count modulus (legal range 2..2^WIDTH); the count range is 0..MODULUS-1.
REQ-003 Parameter PRESCALE, default 1, SHALL set the number of enabled cycles per count step (legal range 1..65535).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-006 Port en, input, 1, SHALL be count enable; the prescaler and count are frozen while en=0.
REQ-007 Port up_dn, input, 1, SHALL select direction: 1=up, 0=down.
REQ-008 Port oneshot, input, 1, SHALL select mode: 1=stop at terminal count, 0=wrap freely.
REQ-009 Port load, input, 1, SHALL request a synchronous parallel load.
REQ-010 Port load_val, input, WIDTH, SHALL be the load value.
REQ-011 Port q, output, WIDTH, SHALL be the registered count.
REQ-012 Port tc, output, 1, SHALL be the registered terminal-count pulse.
REQ-013 Port done, output, 1, SHALL be the registered one-shot-complete flag.

Function
REQ-014 Priority per edge SHALL be rst > load > count step.
REQ-015 On load, q SHALL take load_val if load_val < MODULUS, else MODULUS-1; the prescaler SHALL clear to 0, done SHALL clear, and tc SHALL be 0 that cycle.
REQ-016 The prescaler SHALL be a 0..PRESCALE-1 counter that advances on each en=1 edge; a step SHALL occur on the edge where en=1 and prescaler=PRESCALE-1, and the prescaler SHALL then return to 0. With PRESCALE=1, every en=1 edge SHALL be a step.
REQ-017 Up step: q SHALL increment by 1; from MODULUS-1 it SHALL wrap to 0.
REQ-018 Down step: q SHALL decrement by 1; from 0 it SHALL wrap to MODULUS-1.
REQ-019 tc SHALL be 1 for exactly the single cycle in which q first shows the post-wrap value (free mode) or the held terminal value (one-shot), and 0 otherwise.
REQ-020 In one-shot mode, a step that would wrap SHALL leave q unchanged, set done=1, and pulse tc once. While done=1, further steps SHALL be ignored until load or rst.
REQ-021 If oneshot is deasserted while done=1, done SHALL stay 1 and counting SHALL remain halted until load or rst.
REQ-022 A change of up_dn or oneshot SHALL take effect at the next step; it SHALL NOT disturb the prescaler.
REQ-023 Simultaneous load and step: the load SHALL win, and no tc SHALL be generated.
REQ-024 The design SHALL contain no derived or gated clocks; all flops SHALL be on clk.

Reset
REQ-025 While rst=1 at an edge, the following SHALL be zero: q, the prescaler, tc, done, and (if present) q_gray.
REQ-026 Reset asserted mid-count or mid-prescale SHALL abort the operation, with no tc emitted.

Configuration
REQ-027 Macro MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN, when defined, SHALL add output port q_gray (WIDTH bits), registered and equal to q ^ (q >> 1) in the same cycle as q.
REQ-028 When that macro is undefined, port q_gray and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Free up-count: WIDTH=4, MODULUS=10, PRESCALE=1, en=1, up_dn=1, for 12 cycles -> q goes 1..9,0,1,2 and tc=1 only when q=0.
REQ-030 Down wrap: MODULUS=10, load_val=1, then down for 3 steps -> q goes 1,0,9,8 and tc=1 when q=9.
REQ-031 Prescale: PRESCALE=3, en=1 for 9 cycles -> q steps once every 3 cycles, reaching 3; toggling en=0 for 2 cycles extends the interval by exactly 2.
REQ-032 One-shot: MODULUS=10, oneshot=1, load_val=7, up -> q goes 8,9,9,...; done=1 and tc=1 once at the hold; a subsequent load of 2 clears done and counting resumes.
REQ-033 Load clamp and priority: load_val=15 with MODULUS=10 -> q=9; load on the same edge as a wrap step -> q=load value, tc=0.
REQ-034 Reset mid-run: rst=1 when q=5 and prescaler=1 -> next edge q=0, tc=0, done=0; with the GRAY_OUT_EN macro defined, q=6 gives q_gray=5.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Prescaled modulo-N up/down counter with clamped parallel load, one-shot hold and tc pulse.
// Define MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN to add the registered Gray-coded output q_gray.
module mod_n_updown_counter #(
   parameter int unsigned     WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter int unsigned     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             done
`ifdef MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] q_gray
`endif
);

   localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PresTop = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 64'd1);
   // MODULUS may equal 2^WIDTH, so the load comparison needs one extra bit.
   localparam logic [WIDTH:0]   ModExt  = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] q_q, q_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;

   logic             step;
   logic             at_term;
   logic             load_ok;
   logic [WIDTH-1:0] q_next;

   always_comb begin
      step    = en && (presc_q == PresTop);
      at_term = up_dn ? (q_q == MaxVal) : (q_q == '0);
      load_ok = ({1'b0, load_val} < ModExt);
      if (up_dn) begin
         q_next = at_term ? '0 : q_q + WIDTH'(1);
      end else begin
         q_next = at_term ? MaxVal : q_q - WIDTH'(1);
      end
   end

   always_comb begin
      q_d     = q_q;
      presc_d = presc_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      if (load) begin
         q_d     = load_ok ? load_val : MaxVal;
         presc_d = '0;
         done_d  = 1'b0;
      end else begin
         if (en) begin
            presc_d = step ? '0 : presc_q + PW'(1);
         end
         // Once done is set, steps are swallowed until load or rst, whatever oneshot does.
         if (step && !done_q) begin
            if (at_term && oneshot) begin
               done_d = 1'b1;
               tc_d   = 1'b1;
            end else begin
               q_d  = q_next;
               tc_d = at_term;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q     <= '0;
         presc_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         presc_q <= presc_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

`ifdef MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN
   logic [WIDTH-1:0] gray_q;

   // Encoded from q_d so q_gray updates in the same cycle as q.
   always_ff @(posedge clk) begin
      if (rst) begin
         gray_q <= '0;
      end else begin
         gray_q <= q_d ^ (q_d >> 1);
      end
   end

   assign q_gray = gray_q;
`endif

   assign q    = q_q;
   assign tc   = tc_q;
   assign done = done_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: vector table and hand sequences plus random run against a model.
// Two instances (MODULUS=10) differ only in PRESCALE: 1 and 3.
module tb_mod_n_updown_counter;

   localparam int MOD = 10;

   logic       clk;
   logic       rst, en, up_dn, oneshot, load;
   logic [3:0] load_val;
   logic [3:0] q1, q3;
   logic       tc1, tc3, done1, done3;
`ifdef MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN
   logic [3:0] g1, g3;
`endif

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut_p1 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .oneshot(oneshot), .load(load),
      .load_val(load_val), .q(q1), .tc(tc1), .done(done1)
`ifdef MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN
      , .q_gray(g1)
`endif
   );

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_dut_p3 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .oneshot(oneshot), .load(load),
      .load_val(load_val), .q(q3), .tc(tc3), .done(done3)
`ifdef MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN
      , .q_gray(g3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit r, e, u, o, l;
      int lv;
      int q;
      bit tc, dn;
   } vec_t;

   vec_t vecs[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   // Reference model state, index 0 -> PRESCALE=1, index 1 -> PRESCALE=3.
   int   ps[2] = '{1, 3};
   int   m_q[2], m_p[2];
   bit   m_tc[2], m_done[2];

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic add(input bit r, e, u, o, l, input int lv, input int qv, input bit t, d);
      vec_t v;
      v.r = r; v.e = e; v.u = u; v.o = o; v.l = l; v.lv = lv; v.q = qv; v.tc = t; v.dn = d;
      vecs.push_back(v);
   endtask

   task automatic model_step(input int k);
      bit st, wrap;
      if (rst) begin
         m_q[k] = 0; m_p[k] = 0; m_tc[k] = 0; m_done[k] = 0;
      end else if (load) begin
         m_q[k] = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
         m_p[k] = 0; m_tc[k] = 0; m_done[k] = 0;
      end else begin
         m_tc[k] = 0;
         st = 0;
         if (en) begin
            m_p[k] = (m_p[k] + 1) % ps[k];
            st = (m_p[k] == 0);
         end
         if (st && !m_done[k]) begin
            wrap = up_dn ? (m_q[k] == MOD - 1) : (m_q[k] == 0);
            if (wrap && oneshot) begin
               m_done[k] = 1; m_tc[k] = 1;
            end else begin
               m_q[k]  = up_dn ? (m_q[k] + 1) % MOD : (m_q[k] + MOD - 1) % MOD;
               m_tc[k] = wrap;
            end
         end
      end
   endtask

   task automatic cycle(input bit r, e, u, o, l, input int lv);
      @(negedge clk);
      rst = r; en = e; up_dn = u; oneshot = o; load = l; load_val = 4'(lv);
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
   endtask

   task automatic check_models(input int n);
      check($sformatf("rnd%0d p1.q", n), q1, m_q[0]);
      check($sformatf("rnd%0d p1.tc", n), tc1, m_tc[0]);
      check($sformatf("rnd%0d p1.done", n), done1, m_done[0]);
      check($sformatf("rnd%0d p3.q", n), q3, m_q[1]);
      check($sformatf("rnd%0d p3.tc", n), tc3, m_tc[1]);
      check($sformatf("rnd%0d p3.done", n), done3, m_done[1]);
`ifdef MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN
      check($sformatf("rnd%0d p1.gray", n), g1, m_q[0] ^ (m_q[0] >> 1));
      check($sformatf("rnd%0d p3.gray", n), g3, m_q[1] ^ (m_q[1] >> 1));
`endif
   endtask

   initial begin
      bit cu, co;
      rst = 0; en = 0; up_dn = 0; oneshot = 0; load = 0; load_val = '0;

      // Vector table for the PRESCALE=1 instance: {rst,en,up,oneshot,load,load_val} -> q,tc,done
      add(1, 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) add(0, 1, 1, 0, 0, 0, i % 10, (i % 10) == 0, 0);
      add(0, 0, 1, 0, 0, 0, 2, 0, 0);                  // en=0 freezes
      add(0, 0, 0, 0, 1, 1, 1, 0, 0);                  // down wrap
      add(0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 9, 1, 0);
      add(0, 1, 0, 0, 0, 0, 8, 0, 0);
      add(0, 0, 1, 1, 1, 7, 7, 0, 0);                  // one-shot up
      add(0, 1, 1, 1, 0, 0, 8, 0, 0);
      add(0, 1, 1, 1, 0, 0, 9, 0, 0);
      add(0, 1, 1, 1, 0, 0, 9, 1, 1);
      add(0, 1, 1, 1, 0, 0, 9, 0, 1);
      add(0, 1, 1, 1, 0, 0, 9, 0, 1);
      add(0, 1, 1, 1, 1, 2, 2, 0, 0);
      add(0, 1, 1, 1, 0, 0, 3, 0, 0);
      add(0, 0, 1, 1, 1, 9, 9, 0, 0);                  // oneshot dropped while done
      add(0, 1, 1, 1, 0, 0, 9, 1, 1);
      add(0, 1, 1, 0, 0, 0, 9, 0, 1);
      add(0, 1, 0, 0, 0, 0, 9, 0, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0, 0);                  // one-shot down hold at 0
      add(0, 1, 0, 1, 0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 1, 15, 9, 0, 0);                 // clamp
      add(0, 0, 1, 0, 1, 10, 9, 0, 0);
      add(0, 1, 1, 0, 1, 4, 4, 0, 0);                  // load beats wrap step
      add(0, 1, 1, 0, 0, 0, 5, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0, 0);                  // reset mid-run
      add(0, 0, 1, 0, 1, 5, 5, 0, 0);
      add(0, 1, 1, 0, 0, 0, 6, 0, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].o, vecs[i].l, vecs[i].lv);
         check($sformatf("vec%0d.q", i), q1, vecs[i].q);
         check($sformatf("vec%0d.tc", i), tc1, vecs[i].tc);
         check($sformatf("vec%0d.done", i), done1, vecs[i].dn);
`ifdef MOD_N_UPDOWN_COUNTER_GRAY_OUT_EN
         check($sformatf("vec%0d.gray", i), g1, vecs[i].q ^ (vecs[i].q >> 1));
`endif
      end

      // Prescale=3: nine enabled edges give three steps, no tc.
      cycle(1, 0, 1, 0, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         cycle(0, 1, 1, 0, 0, 0);
         check($sformatf("pre%0d.q", i), q3, i / 3);
         check($sformatf("pre%0d.tc", i), tc3, 0);
      end
      // en low for two cycles stretches the next interval from 3 to 5 edges.
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      check("stretch.hold", q3, 3);
      cycle(0, 1, 1, 0, 0, 0);
      check("stretch.step", q3, 4);

      // Reset with q=5, prescaler=1 aborts; prescaler restarts from 0.
      cycle(0, 0, 1, 0, 1, 5);
      cycle(0, 1, 1, 0, 0, 0);
      check("rstmid.pre_q", q3, 5);
      cycle(1, 1, 1, 0, 0, 0);
      check("rstmid.q", q3, 0);
      check("rstmid.tc", tc3, 0);
      check("rstmid.done", done3, 0);
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      check("rstmid.presc_cleared", q3, 0);
      cycle(0, 1, 1, 0, 0, 0);
      check("rstmid.first_step", q3, 1);

      // Load clears a half-run prescaler; a direction flip mid-prescale keeps the schedule.
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 1, 6);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      check("ldpre.hold", q3, 6);
      cycle(0, 1, 0, 0, 0, 0);
      check("ldpre.step_down", q3, 5);

      // Random run against the model on both instances.
      cycle(1, 0, 1, 0, 0, 0);
      cu = 1; co = 0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 7) == 0) cu = ~cu;
         if ($urandom_range(0, 15) == 0) co = ~co;
         cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, cu, co,
               $urandom_range(0, 15) == 0, $urandom_range(0, 15));
         check_models(n);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
